// File: rtl/serial_adder_acc_if.sv
// Operand/result handshake bundle for the bit-serial adder/accumulator.
// Latency: none, signal grouping only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface serial_adder_acc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             clear_acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, mode, clear_acc, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, mode, clear_acc, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/serial_adder_acc.sv
// Bit-serial LSB-first adder with optional running-sum accumulator, one full-adder cell plus carry flop.
// Latency: out_valid rises WIDTH clocks after the accept edge; one result per WIDTH+2 clocks back-to-back.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module serial_adder_acc #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_acc_if.slave io
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry, carry_nxt, bit_s;
    logic             mode_q, cout_q, ovf_q;
    logic             accept, last;

    assign accept    = (state == IDLE) && io.in_valid;
    assign last      = (state == RUN) && (cnt == LAST);
    assign bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign res_nxt   = {bit_s, res_sh};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.in_valid) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    if (io.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            mode_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_sh   <= io.a;
            b_sh   <= io.mode ? acc : io.b;
            mode_q <= io.mode;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt[WIDTH-1:1];
            carry  <= carry_nxt;
            cnt    <= cnt + 1'b1;
            // carry still holds the carry into the MSB on the final bit
            if (last) begin
                sum_q  <= res_nxt;
                cout_q <= carry_nxt;
                ovf_q  <= carry ^ carry_nxt;
            end
        end
    end

    // Clear wins over a coincident accumulate; an operation in flight already latched its B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 acc <= '0;
        else if (io.clear_acc)   acc <= '0;
        else if (last && mode_q) acc <= res_nxt;
    end

    assign io.in_ready  = (state == IDLE) && !rst;
    assign io.busy      = (state != IDLE);
    assign io.out_valid = (state == DONE);
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder_acc.sv
// Directed bench for serial_adder_acc at WIDTH=8 and WIDTH=16.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_adder_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    serial_adder_acc_if #(.WIDTH(8))  if8 ();
    serial_adder_acc_if #(.WIDTH(16)) if16 ();

    serial_adder_acc #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .io(if8));
    serial_adder_acc #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .io(if16));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic m, input bit clr_last,
                       output logic [7:0] s, output logic c, output logic o, output int lat);
        if8.a = av; if8.b = bv; if8.mode = m; if8.in_valid = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
        lat = 0;
        while (!if8.out_valid && lat < 50) begin
            if (clr_last && lat == 7) if8.clear_acc = 1'b1;
            @(negedge clk);
            if8.clear_acc = 1'b0;
            lat++;
        end
        s = if8.sum; c = if8.cout; o = if8.ovf;
        if (if8.out_ready) @(negedge clk);
    endtask

    task automatic do8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic m,
                       input logic [7:0] es, input logic ec, input logic eo);
        logic [7:0] s; logic c, o; int lat;
        op8(av, bv, m, 1'b0, s, c, o, lat);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_sum"}, s, es);
        check({tag, "_cout"}, c, ec);
        check({tag, "_ovf"}, o, eo);
    endtask

    task automatic do16(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic m,
                        input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        if16.a = av; if16.b = bv; if16.mode = m; if16.in_valid = 1'b1;
        @(negedge clk);
        if16.in_valid = 1'b0;
        lat = 0;
        while (!if16.out_valid && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, 16);
        check({tag, "_sum"}, if16.sum, es);
        check({tag, "_cout"}, if16.cout, ec);
        check({tag, "_ovf"}, if16.ovf, eo);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  s8;
        logic        c8, o8;
        int          lat;
        logic [15:0] ra, rb, acc16;
        logic [16:0] full;

        {if8.in_valid, if8.a, if8.b, if8.mode, if8.clear_acc} = '0;
        {if16.in_valid, if16.a, if16.b, if16.mode, if16.clear_acc} = '0;
        if8.out_ready = 1'b1;
        if16.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", if8.in_ready, 0);
        check("rst_busy", if8.busy, 0);
        check("rst_out_valid", if8.out_valid, 0);
        check("rst_sum", if8.sum, 0);
        check("rst_cout_ovf", {if8.cout, if8.ovf}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", if8.in_ready, 1);

        do8("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
        do8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do8("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // accumulate: clear, then 5 three times, then F5 wraps
        if8.clear_acc = 1'b1;
        @(negedge clk);
        if8.clear_acc = 1'b0;
        do8("acc1", 8'h05, 8'hEE, 1'b1, 8'h05, 1'b0, 1'b0);
        do8("acc2", 8'h05, 8'hEE, 1'b1, 8'h0A, 1'b0, 1'b0);
        do8("acc3", 8'h05, 8'hEE, 1'b1, 8'h0F, 1'b0, 1'b0);
        do8("acc_wrap", 8'hF5, 8'h00, 1'b1, 8'h04, 1'b1, 1'b0);
        do8("acc_keep", 8'h00, 8'h77, 1'b1, 8'h04, 1'b0, 1'b0);

        // result held while the consumer stalls; operands offered meanwhile are ignored
        if8.out_ready = 1'b0;
        op8(8'h12, 8'h34, 1'b0, 1'b0, s8, c8, o8, lat);
        check("hold_first", s8, 8'h46);
        for (int i = 0; i < 5; i++) begin
            if8.in_valid = 1'b1; if8.a = 8'hAA; if8.b = 8'h55;
            @(negedge clk);
            check("hold_out_valid", if8.out_valid, 1);
            check("hold_sum", if8.sum, 8'h46);
            check("hold_in_ready", if8.in_ready, 0);
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", if8.out_valid, 0);
        check("release_sum_kept", if8.sum, 8'h46);
        @(negedge clk);
        check("no_ghost_op", if8.busy, 0);

        // reset during bit 3 of an operation
        if8.a = 8'h55; if8.b = 8'h11; if8.mode = 1'b0; if8.in_valid = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("run_busy", if8.busy, 1);
        check("run_in_ready", if8.in_ready, 0);
        rst = 1'b1;
        #1;
        check("arst_sum", if8.sum, 0);
        check("arst_flags", {if8.out_valid, if8.in_ready, if8.busy, if8.cout, if8.ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do8("post_rst", 8'h21, 8'h42, 1'b0, 8'h63, 1'b0, 1'b0);
        do8("post_rst_acc", 8'h03, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0);

        // clear coincident with the accumulate update edge
        op8(8'h10, 8'h00, 1'b1, 1'b1, s8, c8, o8, lat);
        check("clr_race_lat", lat, 8);
        check("clr_race_sum", s8, 8'h13);
        do8("clr_race_acc", 8'h01, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

        // WIDTH=16
        do16("w16_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do16("w16_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            full = {1'b0, ra} + {1'b0, rb};
            do16("w16_rand", ra, rb, 1'b0, full[15:0], full[16],
                 (ra[15] == rb[15]) && (full[15] != ra[15]));
        end
        acc16 = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            ra = 16'($urandom);
            full = {1'b0, acc16} + {1'b0, ra};
            do16("w16_acc", ra, 16'h0000, 1'b1, full[15:0], full[16],
                 (ra[15] == acc16[15]) && (full[15] != ra[15]));
            acc16 = full[15:0];
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
